instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Producer end of the opcode interface that the main control decoder consumes.
- Accepts symbolic instruction requests (class plus register/immediate fields) over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS word: LW, SW, BEQ or R-type.
- Writes the words sequentially into instruction memory, one per cycle, from a base word address; used for bench and boot-time program loading.

Parameters:
- ADDR_W, 6: width of the instruction-memory word address.
- DEPTH, 64: maximum instructions per load session; must be <= 2^ADDR_W.
- BASE_ADDR, 0: word address of the first written instruction.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a load session; sampled only in IDLE.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts the request this cycle.
- req_op  in  2  instruction class: 00 R-type, 01 LW, 10 SW, 11 BEQ.
- req_rs  in  5  rs field.
- req_rt  in  5  rt field.
- req_rd  in  5  rd field; R-type only.
- req_funct  in  6  funct field; R-type only.
- req_imm  in  16  immediate/offset; LW, SW, BEQ only.
- req_last  in  1  marks the final instruction of the session.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  high in LOAD.
- done  out  1  one-cycle pulse coincident with the final write.
- err  out  1  sticky overflow flag; cleared by the next accepted start.
- count  out  ADDR_W+1  number of instructions accepted this session.

Behaviour:
- Reset is asynchronous, active-low, single clock.
- While reset_n=0: state=IDLE and all outputs are 0, including imem_we, which drops immediately.
- Reset mid-session aborts the session with no further writes; memory contents already written are untouched.
- States:
  - IDLE: start=1 -> LOAD, with count<=0 and err<=0.
  - LOAD: busy=1. A request is accepted when req_valid & req_ready.
    - Accept with req_last=1 -> DONE.
    - Accept with req_last=0 that brings count to DEPTH -> DONE with err<=1.
    - Otherwise stay in LOAD.
  - DONE: lasts exactly one cycle, then -> IDLE.
- req_ready = (state==LOAD) & (count<DEPTH); this is combinational from state and count only, never from req_valid.
- start is ignored outside IDLE.
- Latency and throughput:
  - A request accepted at edge N produces imem_we=1 for the whole cycle after N, with registered imem_addr and imem_wdata.
  - Throughput is 1 instruction per cycle; back-to-back accepts give consecutive write cycles.
  - imem_we=0 in any cycle not following an accept.
- Addressing: imem_addr = (BASE_ADDR + index) mod 2^ADDR_W, where index is the pre-increment value of count. Wrap-around past the top address is silent.
- count increments on each accept and saturates at DEPTH. It holds its value after DONE until the next start.
- Encoding, bits [31:0]:
  - R-type: {000000, rs, rt, rd, 00000, funct}. shamt is always 0; imm is ignored.
  - LW: {100011, rs, rt, imm}.
  - SW: {101011, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}.
  - For LW, SW and BEQ, rd and funct are ignored.
- done=1 only in the DONE cycle, which is the cycle carrying the final write.
- err stays set through IDLE until the next start.
- Request fields are sampled only on accept; values while req_ready=0 have no effect.

Test Plan:
- Reset then start; send LW rs=29 rt=8 imm=0x0004 with last=1 -> next cycle imem_we=1, addr=0, wdata=0x8FA80004, done=1; then IDLE with busy=0 and count=1.
- Stream of four back-to-back requests with last on the fourth:
  - R-type add rs=9 rt=10 rd=8 funct=0x20 -> 0x012A4020.
  - SW rs=29 rt=8 imm=8 -> 0xAFA80008.
  - BEQ rs=8 rt=9 imm=0xFFFF -> 0x1109FFFF.
  - R-type sub rs=1 rt=2 rd=3 funct=0x22 -> 0x00221822.
  - Required: writes on 4 consecutive cycles at addresses 0..3; done coincides with the 4th write.
- Handshake: req_valid toggled with gaps and reset_n held high -> one write per accept, no duplicate or missing writes; fields changed while not accepted are never written.
- Overflow with DEPTH=4 and no last -> 4 writes; req_ready=0 after the 4th accept; err=1 and done pulses; err clears on the next start.
- BASE_ADDR=62, ADDR_W=6, three requests -> addresses 62, 63, 0.
- reset_n asserted low during the cycle after an accept -> imem_we falls immediately, all outputs 0; a subsequent start begins again at BASE_ADDR with count=0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Program loader for instruction memory.
// Takes symbolic instruction requests over a valid/ready handshake and encodes
// each one as a 32-bit MIPS word (R-type, LW, SW or BEQ). It writes the words
// one per cycle to consecutive word addresses, starting at BASE_ADDR.
module instr_encoder_loader #(
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [5:0]        req_funct,
    input  logic [15:0]       req_imm,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;

    // Build the MIPS word for one request. Fields that do not apply to the
    // instruction class are dropped, and shamt is always zero.
    function automatic logic [31:0] encode_instr(
        input logic [1:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [5:0]  funct,
        input logic [15:0] imm
    );
        logic [31:0] word;
        word = 32'd0;
        case (op)
            2'b00:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
            2'b01:   word = {OPC_LW, rs, rt, imm};
            2'b10:   word = {OPC_SW, rs, rt, imm};
            2'b11:   word = {OPC_BEQ, rs, rt, imm};
            default: word = 32'd0;
        endcase
        return word;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_s;
    logic                accept_s;
    logic [ADDR_W:0]     count_inc_s;

    // Ready depends only on state and count, never on req_valid, so there is
    // no combinational loop through the producer.
    assign ready_s     = (state_q == ST_LOAD) && (count_q < DEPTH_C);
    assign accept_s    = req_valid && ready_s;
    assign count_inc_s = count_q + {{ADDR_W{1'b0}}, 1'b1};

    // Next-state, session bookkeeping and the write port for the next cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    count_d = {(ADDR_W+1){1'b0}};
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    we_d    = 1'b1;
                    // The sum wraps silently modulo 2^ADDR_W.
                    addr_d  = BASE_C + count_q[ADDR_W-1:0];
                    wdata_d = encode_instr(req_op, req_rs, req_rt, req_rd,
                                           req_funct, req_imm);
                    count_d = count_inc_s;
                    if (req_last) begin
                        state_d = ST_DONE;
                    end else if (count_inc_s == DEPTH_C) begin
                        // The session filled up before a last marker arrived.
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_LOAD);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers. Reset clears every output immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= {(ADDR_W+1){1'b0}};
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign req_ready  = ready_s;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader.
// Two instances share the same stimulus: one uses the default parameters, and
// the other is a small wrapping configuration (DEPTH=4, BASE_ADDR=62). Each
// instance is checked against its own session-level reference model.
module tb_instr_encoder_loader;

    logic clk;
    logic reset_n;
    logic start;
    logic req_valid;
    logic [1:0]  req_op;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [5:0]  req_funct;
    logic [15:0] req_imm;
    logic        req_last;

    logic [1:0]        o_ready, o_we, o_busy, o_done, o_err;
    logic [1:0][5:0]   o_addr;
    logic [1:0][31:0]  o_wdata;
    logic [1:0][6:0]   o_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, indexed by instance.
    int p_depth[2] = '{64, 4};
    int p_base[2]  = '{0, 62};
    int m_mode[2];          // 0 idle, 1 loading, 2 finishing
    int m_cnt[2];
    bit m_err[2];
    bit m_we[2];
    int m_addr[2];
    logic [31:0] m_wdata[2];

    instr_encoder_loader #(.ADDR_W(6), .DEPTH(64), .BASE_ADDR(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .req_valid(req_valid), .req_ready(o_ready[0]),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_funct(req_funct), .req_imm(req_imm), .req_last(req_last),
        .imem_we(o_we[0]), .imem_addr(o_addr[0]), .imem_wdata(o_wdata[0]),
        .busy(o_busy[0]), .done(o_done[0]), .err(o_err[0]), .count(o_count[0])
    );

    instr_encoder_loader #(.ADDR_W(6), .DEPTH(4), .BASE_ADDR(62)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .req_valid(req_valid), .req_ready(o_ready[1]),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_funct(req_funct), .req_imm(req_imm), .req_last(req_last),
        .imem_we(o_we[1]), .imem_addr(o_addr[1]), .imem_wdata(o_wdata[1]),
        .busy(o_busy[1]), .done(o_done[1]), .err(o_err[1]), .count(o_count[1])
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Encoding by field weights: opcode<<26, rs<<21, rt<<16, rd<<11.
    function automatic logic [31:0] ref_enc(int op, int rs, int rt, int rd, int fn, int imm);
        longint w;
        if (op == 0) begin
            w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + fn;
        end else begin
            w = (op == 1 ? 64'd35 : (op == 2 ? 64'd43 : 64'd4)) * 64'd67108864
                + rs * 64'd2097152 + rt * 64'd65536 + imm;
        end
        return w[31:0];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_cnt[d] = 0; m_err[d] = 1'b0;
            m_we[d] = 1'b0; m_addr[d] = 0; m_wdata[d] = 32'd0;
        end
    endtask

    // Advance each session model by one clock edge using the current inputs.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            m_we[d] = 1'b0;
            if (m_mode[d] == 0) begin
                if (start) begin
                    m_mode[d] = 1; m_cnt[d] = 0; m_err[d] = 1'b0;
                end
            end else if (m_mode[d] == 1) begin
                if (req_valid && m_cnt[d] < p_depth[d]) begin
                    m_we[d]    = 1'b1;
                    m_addr[d]  = (p_base[d] + m_cnt[d]) % 64;
                    m_wdata[d] = ref_enc(int'(req_op), int'(req_rs), int'(req_rt),
                                         int'(req_rd), int'(req_funct), int'(req_imm));
                    m_cnt[d]++;
                    if (req_last) begin
                        m_mode[d] = 2;
                    end else if (m_cnt[d] == p_depth[d]) begin
                        m_mode[d] = 2; m_err[d] = 1'b1;
                    end
                end
            end else begin
                m_mode[d] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_we", d), o_we[d], m_we[d]);
            if (m_we[d]) begin
                chk($sformatf("d%0d_addr", d), o_addr[d], m_addr[d]);
                chk($sformatf("d%0d_wdata", d), o_wdata[d], m_wdata[d]);
            end
            chk($sformatf("d%0d_done", d), o_done[d], m_mode[d] == 2);
            chk($sformatf("d%0d_busy", d), o_busy[d], m_mode[d] == 1);
            chk($sformatf("d%0d_err", d), o_err[d], m_err[d]);
            chk($sformatf("d%0d_count", d), o_count[d], m_cnt[d]);
            chk($sformatf("d%0d_ready", d), o_ready[d], m_mode[d] == 1 && m_cnt[d] < p_depth[d]);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic [1:0] op,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [5:0] fn, input logic [15:0] imm, input logic last);
        start = s; req_valid = v; req_op = op; req_rs = rs; req_rt = rt;
        req_rd = rd; req_funct = fn; req_imm = imm; req_last = last;
    endtask

    // One clock: the edge updates the model, then the following falling edge checks.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_step();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0);
        step();
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_we"}, o_we[d], 1'b0);
            chk({tag, "_addr"}, o_addr[d], 6'd0);
            chk({tag, "_wdata"}, o_wdata[d], 32'd0);
            chk({tag, "_busy"}, o_busy[d], 1'b0);
            chk({tag, "_done"}, o_done[d], 1'b0);
            chk({tag, "_err"}, o_err[d], 1'b0);
            chk({tag, "_count"}, o_count[d], 7'd0);
            chk({tag, "_ready"}, o_ready[d], 1'b0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("rst");
        reset_n = 1'b1;
        idle_step();

        // Single LW with the last marker.
        drive(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0); step();
        drive(1'b0, 1'b1, 2'd1, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0004, 1'b1); step();
        chk("lw_we", o_we[0], 1'b1);
        chk("lw_addr", o_addr[0], 6'd0);
        chk("lw_wdata", o_wdata[0], 32'h8FA80004);
        chk("lw_done", o_done[0], 1'b1);
        idle_step();
        chk("lw_busy_after", o_busy[0], 1'b0);
        chk("lw_count_after", o_count[0], 7'd1);

        // Four back-to-back requests; last on the fourth.
        drive(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0); step();
        drive(1'b0, 1'b1, 2'd0, 5'd9, 5'd10, 5'd8, 6'h20, 16'h1234, 1'b0); step();
        chk("s0_wdata", o_wdata[0], 32'h012A4020); chk("s0_addr", o_addr[0], 6'd0);
        chk("s0_done", o_done[0], 1'b0);
        drive(1'b0, 1'b1, 2'd2, 5'd29, 5'd8, 5'd17, 6'h3F, 16'h0008, 1'b0); step();
        chk("s1_wdata", o_wdata[0], 32'hAFA80008); chk("s1_addr", o_addr[0], 6'd1);
        drive(1'b0, 1'b1, 2'd3, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFF, 1'b0); step();
        chk("s2_wdata", o_wdata[0], 32'h1109FFFF); chk("s2_addr", o_addr[0], 6'd2);
        drive(1'b0, 1'b1, 2'd0, 5'd1, 5'd2, 5'd3, 6'h22, 16'hFFFF, 1'b1); step();
        chk("s3_wdata", o_wdata[0], 32'h00221822); chk("s3_addr", o_addr[0], 6'd3);
        chk("s3_done", o_done[0], 1'b1); chk("s3_we", o_we[0], 1'b1);
        idle_step();

        // Overflow on the DEPTH=4 instance: five requests without the last marker.
        drive(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0); step();
        chk("ovf_err_cleared_by_start", o_err[1], 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 2'd1, 5'(i), 5'(i + 1), 5'd0, 6'd0, 16'(i * 4), 1'b0);
            step();
            if (i == 3) begin
                chk("ovf_ready_low", o_ready[1], 1'b0);
                chk("ovf_err_set", o_err[1], 1'b1);
                chk("ovf_done", o_done[1], 1'b1);
                chk("ovf_wrap_addr", o_addr[1], 6'd1);
            end
        end
        drive(1'b0, 1'b1, 2'd0, 5'd1, 5'd1, 5'd1, 6'd1, 16'd0, 1'b1); step();
        idle_step();
        chk("ovf_err_sticky", o_err[1], 1'b1);
        drive(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0); step();
        chk("ovf_err_clear", o_err[1], 1'b0);
        drive(1'b0, 1'b1, 2'd3, 5'd2, 5'd3, 5'd0, 6'd0, 16'd7, 1'b1); step();
        idle_step();

        // Randomized traffic with gaps, spurious starts and changing fields.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                  2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  6'($urandom), 16'($urandom), $urandom_range(0, 7) == 0);
            step();
        end
        idle_step(); idle_step();

        // Reset asserted during the write cycle that follows an accept.
        drive(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0); step();
        drive(1'b0, 1'b1, 2'd1, 5'd4, 5'd5, 5'd0, 6'd0, 16'h00AA, 1'b0); step();
        drive(1'b0, 1'b1, 2'd2, 5'd6, 5'd7, 5'd0, 6'd0, 16'h00BB, 1'b0);
        @(posedge clk);
        model_step();
        #1;
        chk("pre_rst_we", o_we[0], 1'b1);
        reset_n = 1'b0;
        #1;
        check_zero("mid_rst");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        check_all();
        drive(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0); step();
        chk("rst_restart_count", o_count[0], 7'd0);
        drive(1'b0, 1'b1, 2'd3, 5'd8, 5'd9, 5'd0, 6'd0, 16'h0010, 1'b1); step();
        chk("rst_restart_addr0", o_addr[0], 6'd0);
        chk("rst_restart_addr1", o_addr[1], 6'd62);
        chk("rst_restart_cnt", o_count[0], 7'd1);
        idle_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
